// File: rtl/serial_pkg.sv
// Shared types and helpers for the serial sum deserializer.
// Optional build macro: SER_PARITY_EN (appends an even-parity bit to each frame).
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD
  } ser_state_t;

  localparam int unsigned SER_DEFAULT_WIDTH = 4;

  // Callers zero-extend narrower vectors; zero padding does not change the result.
  function automatic logic even_parity(input logic [63:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/ser_bit_counter.sv
// Loadable up-counter with a terminal-count flag; tracks the bit position within a frame.
module ser_bit_counter #(
  parameter int unsigned CNT_W   = 2,
  parameter int unsigned MAX_VAL = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == CNT_W'(MAX_VAL));

endmodule

// File: rtl/serial_sum_deserializer.sv
// Collects LSB-first serial sum bits plus final carry into a parallel word (valid/ready out).
// Optional build macro: SER_PARITY_EN adds a trailing even-parity bit and the par_perr output.
module serial_sum_deserializer
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH = SER_DEFAULT_WIDTH,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ser_valid,
  input  logic             ser_first,
  input  logic             ser_bit,
  input  logic             ser_cout,
  output logic             ser_ready,
  output logic             par_valid,
  input  logic             par_ready,
  output logic [WIDTH-1:0] par_sum,
  output logic             par_cout,
  output logic             frame_err
`ifdef SER_PARITY_EN
  ,
  output logic             par_perr
`endif
);

`ifdef SER_PARITY_EN
  localparam int unsigned LAST_IDX = WIDTH;
`else
  localparam int unsigned LAST_IDX = WIDTH - 1;
`endif
  // The parity build needs one extra count value, so widen beyond CNT_W when required.
  localparam int unsigned NEED_W = $clog2(LAST_IDX + 1);
  localparam int unsigned CW     = (CNT_W > NEED_W) ? CNT_W : NEED_W;

  ser_state_t       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             err_q, err_d;
  logic [CW-1:0]    cnt;
  logic             tc;
  logic             cnt_clr, cnt_load, cnt_inc;
  logic             accept;
  logic [WIDTH-1:0] first_vec;
`ifdef SER_PARITY_EN
  logic             hold_cout_q, hold_cout_d;
  logic             perr_q, perr_d;
`endif

  ser_bit_counter #(
    .CNT_W  (CW),
    .MAX_VAL(LAST_IDX)
  ) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr     (cnt_clr),
    .load    (cnt_load),
    .load_val(CW'(1)),
    .inc     (cnt_inc),
    .cnt     (cnt),
    .tc      (tc)
  );

  assign par_valid = (state_q == HOLD);
  assign ser_ready = (state_q == HOLD) ? par_ready : 1'b1;
  assign accept    = ser_valid && ser_ready;
  assign first_vec = {{(WIDTH-1){1'b0}}, ser_bit};

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    err_d    = 1'b0;
    cnt_clr  = 1'b0;
    cnt_load = 1'b0;
    cnt_inc  = 1'b0;
`ifdef SER_PARITY_EN
    hold_cout_d = hold_cout_q;
    perr_d      = perr_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (ser_first) begin
            shreg_d  = first_vec;
            cnt_load = 1'b1;
            state_d  = SHIFT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (accept) begin
          if (ser_first) begin
            // Restart: drop the partial frame and treat this bit as bit 0.
            err_d    = 1'b1;
            shreg_d  = first_vec;
            cnt_load = 1'b1;
          end else if (tc) begin
            cnt_clr = 1'b1;
            state_d = HOLD;
`ifdef SER_PARITY_EN
            sum_d  = shreg_q;
            cout_d = hold_cout_q;
            perr_d = even_parity(64'({ser_bit, hold_cout_q, shreg_q}));
`else
            sum_d            = shreg_q;
            sum_d[WIDTH-1]   = ser_bit;
            cout_d           = ser_cout;
`endif
          end else begin
            cnt_inc = 1'b1;
            for (int i = 0; i < WIDTH; i++) begin
              if (cnt == CW'(i)) shreg_d[i] = ser_bit;
            end
`ifdef SER_PARITY_EN
            if (cnt == CW'(WIDTH - 1)) hold_cout_d = ser_cout;
`endif
          end
        end
      end
      HOLD: begin
        if (par_ready) begin
          state_d = IDLE;
          if (ser_valid) begin
            if (ser_first) begin
              shreg_d  = first_vec;
              cnt_load = 1'b1;
              state_d  = SHIFT;
            end else begin
              err_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
    end
  end

`ifdef SER_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cout_q <= 1'b0;
      perr_q      <= 1'b0;
    end else begin
      hold_cout_q <= hold_cout_d;
      perr_q      <= perr_d;
    end
  end

  assign par_perr = perr_q;
`endif

  assign par_sum   = sum_q;
  assign par_cout  = cout_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_serial_sum_deserializer.sv
// Scoreboard bench for serial_sum_deserializer: directed cases plus randomized traffic.
module tb_serial_sum_deserializer;

  localparam int unsigned WIDTH = 4;
`ifdef SER_PARITY_EN
  localparam int unsigned FL = WIDTH + 1;
`else
  localparam int unsigned FL = WIDTH;
`endif

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             perr;
  } frame_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             ser_valid = 1'b0, ser_first = 1'b0, ser_bit = 1'b0, ser_cout = 1'b0;
  logic             par_ready = 1'b0;
  logic             ser_ready, par_valid, par_cout, frame_err;
  logic [WIDTH-1:0] par_sum;
`ifdef SER_PARITY_EN
  logic             par_perr;
`endif

  serial_sum_deserializer #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .ser_valid(ser_valid),
    .ser_first(ser_first),
    .ser_bit  (ser_bit),
    .ser_cout (ser_cout),
    .ser_ready(ser_ready),
    .par_valid(par_valid),
    .par_ready(par_ready),
    .par_sum  (par_sum),
    .par_cout (par_cout),
    .frame_err(frame_err)
`ifdef SER_PARITY_EN
    ,
    .par_perr (par_perr)
`endif
  );

  always #5 clk = ~clk;

  int     n_vec = 0;
  int     n_bad = 0;
  frame_t sb[$];

  // Reference model: bits of the frame in progress, captured carry, pending output, error.
  logic   mq[$];
  logic   m_cout = 1'b0;
  logic   m_pending = 1'b0;
  logic   m_err = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic v, input logic f, input logic b, input logic c,
                      input logic pr);
    logic   rdy;
    frame_t fr;
    @(negedge clk);
    chk("par_valid", int'(par_valid), int'(m_pending));
    chk("frame_err", int'(frame_err), int'(m_err));
    ser_valid = v;
    ser_first = f;
    ser_bit   = b;
    ser_cout  = c;
    par_ready = pr;
    #1;
    rdy = !m_pending || pr;
    chk("ser_ready", int'(ser_ready), int'(rdy));
    m_err = 1'b0;
    if (m_pending && pr) m_pending = 1'b0;
    if (v && rdy) begin
      if (f) begin
        if (mq.size() != 0) m_err = 1'b1;
        mq.delete();
        mq.push_back(b);
      end else if (mq.size() == 0) begin
        m_err = 1'b1;
      end else begin
        mq.push_back(b);
        if (mq.size() == WIDTH) m_cout = c;
      end
      if (mq.size() == FL) begin
        for (int i = 0; i < WIDTH; i++) fr.sum[i] = mq[i];
        fr.cout = m_cout;
        fr.perr = 1'b0;
        for (int i = 0; i < FL; i++) fr.perr = fr.perr ^ mq[i];
        fr.perr = fr.perr ^ m_cout;
        sb.push_back(fr);
        m_pending = 1'b1;
        mq.delete();
      end
    end
  endtask

  // Drives one complete frame; pbit is the parity bit in the parity build, else ignored.
  task automatic send_frame(input logic [WIDTH-1:0] s, input logic c, input logic pbit,
                            input logic pr);
    for (int i = 0; i < WIDTH; i++) begin
      step(1'b1, (i == 0), s[i], (i == WIDTH - 1) ? c : 1'b0, pr);
    end
    if (FL > WIDTH) step(1'b1, 1'b0, pbit, 1'b0, pr);
  endtask

  function automatic logic good_par(input logic [WIDTH-1:0] s, input logic c);
    return (^s) ^ c;
  endfunction

  task automatic do_reset_mid();
    @(negedge clk);
    ser_valid = 1'b0;
    #3 reset = 1'b1;
    #1;
    chk("rst_par_valid", int'(par_valid), 0);
    chk("rst_par_sum", int'(par_sum), 0);
    chk("rst_frame_err", int'(frame_err), 0);
    chk("rst_ser_ready", int'(ser_ready), 1);
    mq.delete();
    sb.delete();
    m_pending = 1'b0;
    m_err     = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: compares the presented word against the scoreboard head, pops on handshake.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!reset && par_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_frame", 1, 0);
        end else begin
          chk("par_sum", int'(par_sum), int'(sb[0].sum));
          chk("par_cout", int'(par_cout), int'(sb[0].cout));
`ifdef SER_PARITY_EN
          chk("par_perr", int'(par_perr), int'(sb[0].perr));
`endif
          if (par_ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #12;
    chk("init_par_valid", int'(par_valid), 0);
    chk("init_par_sum", int'(par_sum), 0);
    chk("init_par_cout", int'(par_cout), 0);
    chk("init_frame_err", int'(frame_err), 0);
    chk("init_ser_ready", int'(ser_ready), 1);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Single frame 1,0,1,1 with carry 1.
    send_frame(4'b1101, 1'b1, good_par(4'b1101, 1'b1), 1'b1);
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Backpressure, including a stalled bit offered during HOLD.
    send_frame(4'b0110, 1'b0, good_par(4'b0110, 1'b0), 1'b0);
    repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    send_frame(4'b1001, 1'b1, good_par(4'b1001, 1'b1), 1'b1);

    // Back-to-back frames.
    send_frame(4'hF, 1'b1, good_par(4'hF, 1'b1), 1'b1);
    send_frame(4'h0, 1'b0, good_par(4'h0, 1'b0), 1'b1);
    send_frame(4'hA, 1'b0, good_par(4'hA, 1'b0), 1'b1);
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // ser_first reasserted on bit 2, then a stray bit in IDLE.
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    send_frame(4'b0011, 1'b1, good_par(4'b0011, 1'b1), 1'b1);
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset after bit 1, then a clean frame.
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    do_reset_mid();
    send_frame(4'h5, 1'b0, good_par(4'h5, 1'b0), 1'b1);
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

`ifdef SER_PARITY_EN
    send_frame(4'b1011, 1'b0, 1'b1, 1'b1);
    send_frame(4'b1011, 1'b0, 1'b0, 1'b1);
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`endif

    // Randomized traffic.
    for (int n = 0; n < 800; n++) begin
      logic v, f, b, c, pr;
      v  = ($urandom_range(0, 3) != 0);
      f  = (mq.size() == 0) ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 19) == 0);
      b  = 1'($urandom_range(0, 1));
      c  = 1'($urandom_range(0, 1));
      pr = ($urandom_range(0, 9) < 7);
      step(v, f, b, c, pr);
    end

    repeat (6) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
